// File: rtl/seg_scan_decoder.sv
// ============================================================================
// seg_scan_decoder : recovers hex digits from a scanned active-low 7-seg bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int BLANK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anode_in,
  input  logic [6:0]  seg_in,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  seg_error,
  output logic [3:0]  digit_lit,
  output logic        capture_strobe,
  output logic [1:0]  capture_idx
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(BLANK_TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(BLANK_TIMEOUT);

  logic [10:0]   cur;
  logic [10:0]   sample;
  logic [SW-1:0] stable_cnt;
  logic          armed;
  logic          settled;
  logic          anode_onehot;
  logic          seg_blank;
  logic          do_capture;
  logic          glyph_ok;
  logic [1:0]    cap_idx;
  logic [3:0]    glyph_val;

  assign cur        = {anode_in, seg_in};
  assign settled    = armed && (stable_cnt == SETTLE_MAX);
  assign seg_blank  = (sample[6:0] == 7'h7F);
  assign do_capture = settled && anode_onehot && !seg_blank;

  always_comb begin
    anode_onehot = 1'b1;
    cap_idx      = 2'd0;
    case (sample[10:7])
      4'b1110: cap_idx = 2'd0;
      4'b1101: cap_idx = 2'd1;
      4'b1011: cap_idx = 2'd2;
      4'b0111: cap_idx = 2'd3;
      default: anode_onehot = 1'b0;
    endcase
  end

  // Segment order is {g,f,e,d,c,b,a}, active low.
  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    case (sample[6:0])
      7'b1000000: glyph_val = 4'h0;
      7'b1111001: glyph_val = 4'h1;
      7'b0100100: glyph_val = 4'h2;
      7'b0110000: glyph_val = 4'h3;
      7'b0011001: glyph_val = 4'h4;
      7'b0010010: glyph_val = 4'h5;
      7'b0000010: glyph_val = 4'h6;
      7'b1111000: glyph_val = 4'h7;
      7'b0000000: glyph_val = 4'h8;
      7'b0010000: glyph_val = 4'h9;
      7'b0001000: glyph_val = 4'hA;
      7'b0000011: glyph_val = 4'hB;
      7'b1000110: glyph_val = 4'hC;
      7'b0100001: glyph_val = 4'hD;
      7'b0000110: glyph_val = 4'hE;
      7'b0001110: glyph_val = 4'hF;
      default:    glyph_ok  = 1'b0;
    endcase
  end

  // A new pattern re-arms; a settled run fires once and then disarms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample     <= 11'h7FF;
      stable_cnt <= '0;
      armed      <= 1'b1;
    end else begin
      sample <= cur;
      if (cur != sample) begin
        stable_cnt <= SW'(1);
        armed      <= 1'b1;
      end else begin
        if (stable_cnt != SETTLE_MAX) stable_cnt <= stable_cnt + SW'(1);
        if (settled) armed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capture_strobe <= 1'b0;
      capture_idx    <= 2'd0;
    end else begin
      capture_strobe <= do_capture;
      if (do_capture) capture_idx <= cap_idx;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_digit
    logic          hit;
    logic [TW-1:0] idle_cnt;
    logic [3:0]    nib;
    logic          valid;
    logic          err;
    logic          lit;

    assign hit = do_capture && (cap_idx == 2'(i));

    // A capture on the expiry cycle takes priority over blanking.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        idle_cnt <= '0;
        nib      <= 4'h0;
        valid    <= 1'b0;
        err      <= 1'b0;
        lit      <= 1'b0;
      end else if (hit) begin
        idle_cnt <= '0;
        lit      <= 1'b1;
        valid    <= glyph_ok;
        err      <= !glyph_ok;
        if (glyph_ok) nib <= glyph_val;
      end else if (idle_cnt != TIMEOUT_MAX) begin
        idle_cnt <= idle_cnt + TW'(1);
        if (idle_cnt + TW'(1) == TIMEOUT_MAX) lit <= 1'b0;
      end
    end

    assign digits[4*i +: 4] = nib;
    assign digit_valid[i]   = valid;
    assign seg_error[i]     = err;
    assign digit_lit[i]     = lit;
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// ============================================================================
// tb_seg_scan_decoder : randomized self-checking bench with a window model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg_scan_decoder;

  localparam int SETTLE = 4;
  localparam int BT     = 64;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  anode_in;
  logic [6:0]  seg_in;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  seg_error;
  logic [3:0]  digit_lit;
  logic        capture_strobe;
  logic [1:0]  capture_idx;

  int checks  = 0;
  int errors  = 0;
  int strobes = 0;

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .BLANK_TIMEOUT(BT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .anode_in       (anode_in),
    .seg_in         (seg_in),
    .digits         (digits),
    .digit_valid    (digit_valid),
    .seg_error      (seg_error),
    .digit_lit      (digit_lit),
    .capture_strobe (capture_strobe),
    .capture_idx    (capture_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of samples since reset, captures found by window
  logic [10:0] hist[$];
  int          n;
  bit          ever[4];
  int          last_cap[4];
  logic [3:0]  m_nib[4];
  bit          m_valid[4];
  bit          m_err[4];
  bit          m_strobe;
  int          m_idx;

  function automatic int lookup(input logic [6:0] s);
    for (int k = 0; k < 16; k++) if (GLYPH[k] == s) return k;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    n = 0;
    m_strobe = 0;
    m_idx = 0;
    for (int i = 0; i < 4; i++) begin
      ever[i] = 0; last_cap[i] = 0; m_nib[i] = 4'h0; m_valid[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [10:0] s);
    int st, zeros, idx, g;
    bit run;
    logic [10:0] p;
    hist.push_back(s);
    n++;
    m_strobe = 0;
    st = n - 1 - SETTLE;
    if (st >= 0) begin
      p = hist[st];
      run = 1;
      for (int k = st; k <= n - 2; k++) if (hist[k] !== p) run = 0;
      if (st > 0 && hist[st-1] === p) run = 0;
      if (run) begin
        zeros = 0; idx = 0;
        for (int k = 0; k < 4; k++) if (!p[7+k]) begin zeros++; idx = k; end
        if (zeros == 1 && p[6:0] != 7'h7F) begin
          g = lookup(p[6:0]);
          m_strobe = 1;
          m_idx = idx;
          ever[idx] = 1;
          last_cap[idx] = n;
          if (g >= 0) begin
            m_nib[idx] = 4'(g); m_valid[idx] = 1; m_err[idx] = 0;
          end else begin
            m_valid[idx] = 0; m_err[idx] = 1;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    logic [15:0] ed;
    logic [3:0]  ev, ee, el;
    if (rst_n) model_edge({anode_in, seg_in});
    else       model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      ed[4*i +: 4] = m_nib[i];
      ev[i] = m_valid[i];
      ee[i] = m_err[i];
      el[i] = ever[i] && ((n - last_cap[i]) < BT);
    end
    check("digits", digits, ed);
    check("digit_valid", {12'd0, digit_valid}, {12'd0, ev});
    check("seg_error", {12'd0, seg_error}, {12'd0, ee});
    check("digit_lit", {12'd0, digit_lit}, {12'd0, el});
    check("capture_strobe", {15'd0, capture_strobe}, {15'd0, m_strobe});
    check("capture_idx", {14'd0, capture_idx}, 16'(m_idx));
    if (capture_strobe === 1'b1) strobes++;
  end

  function automatic logic [3:0] onehot(input int d);
    return ~(4'b0001 << d);
  endfunction

  // Called on a negedge; drives the pattern for c full clock cycles.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int c);
    anode_in = a;
    seg_in   = s;
    repeat (c) @(negedge clk);
  endtask

  initial begin
    int s0, scan_val[4], found, len, r;
    logic [3:0] a;
    logic [6:0] s;
    scan_val = '{1, 10, 12, 15};
    anode_in = 4'hF;
    seg_in   = 7'h7F;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // First capture latency
    anode_in = 4'b1110;
    seg_in   = 7'b0110000;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #2;
      check("t1_strobe_edge", {15'd0, capture_strobe}, {15'd0, (k == 5)});
      if (k == 5) begin
        check("t1_digit0", {12'd0, digits[3:0]}, 16'h3);
        check("t1_valid", {12'd0, digit_valid}, 16'h1);
        check("t1_lit", {12'd0, digit_lit}, 16'h1);
        check("t1_idx", {14'd0, capture_idx}, 16'h0);
      end
    end
    @(negedge clk);

    // Full scan twice
    s0 = strobes;
    repeat (2) for (int d = 0; d < 4; d++) hold(onehot(d), GLYPH[scan_val[d]], 8);
    check("scan_digits", digits, 16'hFCA1);
    check("scan_valid", {12'd0, digit_valid}, 16'hF);
    check("scan_err", {12'd0, seg_error}, 16'h0);
    check("scan_strobes", 16'(strobes - s0), 16'd8);

    // Glitch then stable unknown pattern on digit 2
    hold(4'b1110, GLYPH[1], 8);
    hold(4'b1101, GLYPH[10], 8);
    s0 = strobes;
    hold(4'b1011, 7'b0101010, 2);
    hold(4'b1111, 7'h7F, 1);
    check("glitch_nostrobe", 16'(strobes - s0), 16'd0);
    hold(4'b1011, 7'b0101010, 8);
    hold(4'b0111, GLYPH[15], 8);
    check("err_strobes", 16'(strobes - s0), 16'd2);
    check("err_seg_error", {12'd0, seg_error}, 16'h4);
    check("err_valid", {12'd0, digit_valid}, 16'hB);
    check("err_digit2", {12'd0, digits[11:8]}, 16'hC);

    // No capture when display off or several anodes low
    s0 = strobes;
    hold(4'b1111, GLYPH[5], 50);
    hold(4'b1100, GLYPH[5], 50);
    check("nocap_strobes", 16'(strobes - s0), 16'd0);
    check("nocap_digits", digits, 16'hFCA1);
    check("nocap_valid", {12'd0, digit_valid}, 16'hB);
    check("nocap_err", {12'd0, seg_error}, 16'h4);

    // Blank timeout on digit 1
    anode_in = 4'b1101;
    seg_in   = GLYPH[5];
    found = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #2;
      if (capture_strobe === 1'b1) begin found = 1; break; end
    end
    check("to_capture_seen", 16'(found), 16'd1);
    @(negedge clk);
    anode_in = 4'b1111;
    seg_in   = 7'h7F;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #2;
      if (k == 63) check("to_lit_before", {15'd0, digit_lit[1]}, 16'd1);
      if (k == 64) check("to_lit_after", {15'd0, digit_lit[1]}, 16'd0);
    end
    check("to_digit1_kept", {12'd0, digits[7:4]}, 16'h5);
    check("to_valid1_kept", {15'd0, digit_valid[1]}, 16'd1);
    @(negedge clk);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r == 6)      a = 4'b1111;
      else if (r == 7) a = 4'($urandom_range(0, 15));
      else             a = onehot($urandom_range(0, 3));
      r = $urandom_range(0, 8);
      if (r <= 6)      s = GLYPH[$urandom_range(0, 15)];
      else if (r == 7) s = 7'h7F;
      else             s = 7'($urandom_range(0, 127));
      len = $urandom_range(1, 9);
      hold(a, s, len);
    end

    // Rescan, then reset mid-scan
    for (int d = 0; d < 4; d++) hold(onehot(d), GLYPH[scan_val[d]], 8);
    check("rescan_valid", {12'd0, digit_valid}, 16'hF);
    check("rescan_idx", {14'd0, capture_idx}, 16'd3);
    hold(4'b1110, GLYPH[1], 3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_digits", digits, 16'h0);
    check("rst_valid", {12'd0, digit_valid}, 16'h0);
    check("rst_err", {12'd0, seg_error}, 16'h0);
    check("rst_lit", {12'd0, digit_lit}, 16'h0);
    check("rst_strobe", {15'd0, capture_strobe}, 16'h0);
    check("rst_idx", {14'd0, capture_idx}, 16'h0);
    anode_in = 4'b1110;
    seg_in   = GLYPH[7];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #2;
      check("rst_settle_edge", {15'd0, capture_strobe}, {15'd0, (k == 5)});
      if (k == 5) check("rst_digit0", {12'd0, digits[3:0]}, 16'h7);
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side decoder for the multiplexed 7-segment display interface: samples the active-low anode and cathode lines driven by the display/blink path and recovers the four hex digits.
- Reports per-digit validity, glyph errors and lit/blanked status, so blinking can be checked in self-checking benches and board-level loopback.
- Sits on the display pins, in parallel with the physical display.

Parameters:
- SETTLE_CYCLES, 4, consecutive identical samples required before a capture (min 2).
- BLANK_TIMEOUT, 1024, cycles without a capture of digit i before digit_lit[i] clears (min 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  active-low reset.
- anode_in  input  4  active-low digit enables; bit i = digit i.
- seg_in  input  7  active-low segments {g,f,e,d,c,b,a}; bit0 = a.
- digits  output  16  recovered nibbles; digit i in [4i+3:4i].
- digit_valid  output  4  digit i holds a successfully decoded glyph.
- seg_error  output  4  last capture of digit i was not a hex glyph.
- digit_lit  output  4  digit i captured lit within the last BLANK_TIMEOUT cycles.
- capture_strobe  output  1  one-cycle pulse per capture.
- capture_idx  output  2  digit index of the current/last capture.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n; all state is cleared on assertion, with no synchronisation of assertion.
- Reset values: digits=0, digit_valid=0, seg_error=0, digit_lit=0, capture_strobe=0, capture_idx=0. The sample register is 11'h7FF, the stability counter is 0, the armed flag is 1 and all timeout counters are 0.
- Sampling: {anode_in, seg_in} is registered every clk.
  - A sample differing from the previous one sets stable_cnt=1 and armed=1.
  - Otherwise stable_cnt increments, saturating at SETTLE_CYCLES.
- Capture condition: stable_cnt reaches SETTLE_CYCLES while armed=1. armed then clears, giving exactly one capture per stable run.
  - Latency: inputs constant from before edge 1 produce the capture outputs after edge SETTLE_CYCLES+1.
- Qualification: a capture is performed only if anode_in is one-hot-low (exactly one bit 0). All-high (display off or blink-blanked) and multiple-low patterns produce no capture and no strobe.
  - seg_in=7'h7F with a valid anode counts as blank: no capture, no error, digit_lit unchanged.
- Glyph table (seg_in to value):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- On capture of digit i with a valid glyph:
  - Digit nibble i is loaded with the value.
  - digit_valid[i]=1, seg_error[i]=0, digit_lit[i]=1.
  - Timeout counter i is cleared.
  - capture_strobe=1 for one cycle; capture_idx=i (capture_idx holds until the next capture).
- On capture with an unknown pattern:
  - Nibble i is unchanged.
  - digit_valid[i]=0, seg_error[i]=1, digit_lit[i]=1.
  - Timeout counter i is cleared; strobe pulses as above.
- Timeout: each digit counter increments every cycle without a capture of that digit, saturating at BLANK_TIMEOUT.
  - digit_lit[i] clears on the cycle the counter reaches BLANK_TIMEOUT.
  - digits and digit_valid are retained through blanking.
- Simultaneous events: a capture of digit i on the same cycle its timeout would expire wins (digit_lit[i] stays 1, counter cleared). Other digits' counters are unaffected.
- Reset mid-operation: outputs return to reset values immediately. The first capture after release needs a full SETTLE_CYCLES stable run.

Test Plan:
- Reset, then hold anode_in=1110, seg_in=0110000 -> capture_strobe once, 5 edges after the change; digits[3:0]=3, digit_valid=0001, digit_lit=0001, capture_idx=0.
- Scan digits 0..3 with glyphs 1,A,C,F, 8 cycles each, repeated twice -> digits=16'hFCA1, digit_valid=1111, seg_error=0000; exactly 8 strobes.
- Same scan, but digit 2 is held for 2 cycles with seg_in=0101010, then stable -> 2-cycle glitch produces no strobe; the stable pattern gives seg_error=0100, digit_valid=1011, digits[11:8] unchanged (C).
- anode_in=1111 and anode_in=1100 with valid glyphs, each for 50 cycles -> no strobes; all outputs unchanged.
- BLANK_TIMEOUT=64: capture digit 1, then keep anode_in=1111 -> digit_lit[1] clears exactly 64 cycles after the capture; digits and digit_valid are retained.
- Assert rst_n=0 mid-scan while digit_valid=1111 -> all outputs 0 immediately; after release the first capture needs SETTLE_CYCLES stable samples.
